// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin arbiter between two data_m masters and one slave.
// Each grant carries one transfer; a slave that never acks is cut off with a bus error.
module data_bus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [18:0] a_m_addr,
   input  logic [15:0] a_m_data_out,
   output logic [15:0] a_m_data_in,
   input  logic        a_m_access,
   output logic        a_m_ack,
   input  logic        a_m_wr_en,
   input  logic [1:0]  a_m_bytesel,
   input  logic [18:0] b_m_addr,
   input  logic [15:0] b_m_data_out,
   output logic [15:0] b_m_data_in,
   input  logic        b_m_access,
   output logic        b_m_ack,
   input  logic        b_m_wr_en,
   input  logic [1:0]  b_m_bytesel,
   output logic [18:0] q_m_addr,
   output logic [15:0] q_m_data_out,
   input  logic [15:0] q_m_data_in,
   output logic        q_m_access,
   input  logic        q_m_ack,
   output logic        q_m_wr_en,
   output logic [1:0]  q_m_bytesel,
   output logic        q_m_owner,
   output logic        bus_error
);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GRANT, ERR} state_t;

   typedef struct packed {
      logic [18:0] addr;
      logic [15:0] wdata;
      logic        wr_en;
      logic [1:0]  bytesel;
   } req_t;

   state_t           state;
   logic             owner;
   logic             last_owner;
   logic             winner;
   logic [CW-1:0]    cnt;
   req_t [1:0]       req;
   logic [1:0]       access;
   logic [1:0]       ack;
   logic [1:0][15:0] rdata;

   assign req[0] = '{addr: a_m_addr, wdata: a_m_data_out, wr_en: a_m_wr_en, bytesel: a_m_bytesel};
   assign req[1] = '{addr: b_m_addr, wdata: b_m_data_out, wr_en: b_m_wr_en, bytesel: b_m_bytesel};
   assign access = {b_m_access, a_m_access};

   // On contention the master that did not own the previous transfer wins.
   assign winner = (&access) ? ~last_owner : access[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|access) begin
                  state      <= GRANT;
                  owner      <= winner;
                  last_owner <= winner;
                  cnt        <= '0;
               end
            end
            GRANT: begin
               // An ack on the final granted cycle still completes normally.
               if (q_m_ack)
                  state <= IDLE;
               else if (cnt == CW'(TIMEOUT - 1))
                  state <= ERR;
               else
                  cnt <= cnt + CW'(1);
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are forced quiet while reset is high so an in-flight transfer never acks.
   always_comb begin
      q_m_access   = 1'b0;
      q_m_addr     = '0;
      q_m_data_out = '0;
      q_m_wr_en    = 1'b0;
      q_m_bytesel  = '0;
      ack          = '0;
      rdata        = '0;
      bus_error    = 1'b0;
      if (!reset) begin
         case (state)
            GRANT: begin
               q_m_access = 1'b1;
               {q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel} = req[owner];
               ack[owner]   = q_m_ack;
               rdata[owner] = q_m_data_in;
            end
            ERR: begin
               ack[owner]   = 1'b1;
               rdata[owner] = 16'hFFFF;
               bus_error    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign q_m_owner   = owner & ~reset;
   assign a_m_ack     = ack[0];
   assign b_m_ack     = ack[1];
   assign a_m_data_in = rdata[0];
   assign b_m_data_in = rdata[1];

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized masters and slave.
module tb_data_bus_arbiter;
   localparam int TO = 4;

   logic        clk, reset;
   logic [18:0] a_m_addr, b_m_addr, q_m_addr;
   logic [15:0] a_m_data_out, b_m_data_out, q_m_data_out;
   logic [15:0] a_m_data_in, b_m_data_in, q_m_data_in;
   logic        a_m_access, b_m_access, q_m_access;
   logic        a_m_ack, b_m_ack, q_m_ack;
   logic        a_m_wr_en, b_m_wr_en, q_m_wr_en;
   logic [1:0]  a_m_bytesel, b_m_bytesel, q_m_bytesel;
   logic        q_m_owner, bus_error;

   data_bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .a_m_addr(a_m_addr), .a_m_data_out(a_m_data_out), .a_m_data_in(a_m_data_in),
      .a_m_access(a_m_access), .a_m_ack(a_m_ack), .a_m_wr_en(a_m_wr_en), .a_m_bytesel(a_m_bytesel),
      .b_m_addr(b_m_addr), .b_m_data_out(b_m_data_out), .b_m_data_in(b_m_data_in),
      .b_m_access(b_m_access), .b_m_ack(b_m_ack), .b_m_wr_en(b_m_wr_en), .b_m_bytesel(b_m_bytesel),
      .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_data_in(q_m_data_in),
      .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
      .q_m_owner(q_m_owner), .bus_error(bus_error)
   );

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Transaction-level model: is a transfer open, who owns it, how many granted
   // cycles it has used, and whether it is in its abort cycle.
   bit          m_busy, m_err, m_own, m_last;
   int          m_n;
   logic        e_acc, e_wr, e_berr;
   logic [18:0] e_addr;
   logic [15:0] e_dout, e_din0, e_din1;
   logic [1:0]  e_bs, e_ack;

   always @(negedge clk) begin
      e_acc = 0; e_wr = 0; e_berr = 0; e_addr = '0; e_dout = '0;
      e_din0 = '0; e_din1 = '0; e_bs = '0; e_ack = '0;
      if (!reset && m_busy && m_err) begin
         e_berr = 1'b1;
         e_ack[m_own] = 1'b1;
         if (m_own) e_din1 = 16'hFFFF; else e_din0 = 16'hFFFF;
      end else if (!reset && m_busy) begin
         e_acc = 1'b1;
         if (m_own) begin
            e_addr = b_m_addr; e_dout = b_m_data_out; e_wr = b_m_wr_en; e_bs = b_m_bytesel;
            e_din1 = q_m_data_in;
         end else begin
            e_addr = a_m_addr; e_dout = a_m_data_out; e_wr = a_m_wr_en; e_bs = a_m_bytesel;
            e_din0 = q_m_data_in;
         end
         e_ack[m_own] = q_m_ack;
      end
      chk("m_access", q_m_access, e_acc);
      chk("m_addr", q_m_addr, e_addr);
      chk("m_dout", q_m_data_out, e_dout);
      chk("m_wr", q_m_wr_en, e_wr);
      chk("m_bsel", q_m_bytesel, e_bs);
      chk("m_a_ack", a_m_ack, e_ack[0]);
      chk("m_b_ack", b_m_ack, e_ack[1]);
      chk("m_a_din", a_m_data_in, e_din0);
      chk("m_b_din", b_m_data_in, e_din1);
      chk("m_berr", bus_error, e_berr);
      if (e_acc || reset) chk("m_owner", q_m_owner, reset ? 1'b0 : m_own);
      // advance the model to the next cycle
      if (reset) begin
         m_busy = 0; m_err = 0; m_last = 1; m_own = 0; m_n = 0;
      end else if (m_busy && m_err) begin
         m_busy = 0; m_err = 0;
      end else if (m_busy) begin
         m_n++;
         if (q_m_ack) m_busy = 0;
         else if (m_n == TO) m_err = 1;
      end else if (a_m_access || b_m_access) begin
         m_own  = (a_m_access && b_m_access) ? !m_last : b_m_access;
         m_last = m_own;
         m_busy = 1;
         m_n    = 0;
      end
   end

   int na = 0, nb = 0, ne = 0;
   always @(negedge clk) begin
      if (a_m_ack) na++;
      if (b_m_ack) nb++;
      if (bus_error) ne++;
   end

   task automatic new_a();
      a_m_addr = 19'($urandom); a_m_data_out = 16'($urandom);
      a_m_wr_en = 1'($urandom); a_m_bytesel = 2'($urandom);
   endtask

   task automatic new_b();
      b_m_addr = 19'($urandom); b_m_data_out = 16'($urandom);
      b_m_wr_en = 1'($urandom); b_m_bytesel = 2'($urandom);
   endtask

   int  na0, nb0, ne0, gc, n, acc, errs;
   bit  pa, pb, a_seen, a_done, b_done, acc_now;
   logic [0:5] order;

   initial begin
      reset = 1; q_m_ack = 0; q_m_data_in = '0;
      a_m_addr = 19'h00001; a_m_data_out = '0; a_m_wr_en = 0; a_m_bytesel = 2'b11; a_m_access = 1;
      b_m_addr = 19'h00002; b_m_data_out = '0; b_m_wr_en = 0; b_m_bytesel = 2'b11; b_m_access = 1;

      // reset with both masters requesting
      for (int i = 0; i < 2; i++) begin
         nxt(); mid();
         chk("rst_access", q_m_access, 0);
         chk("rst_acks", {a_m_ack, b_m_ack, bus_error, q_m_owner}, 0);
         chk("rst_addr", q_m_addr, 0);
      end
      nxt(); reset = 0;
      mid(); chk("rst_idle", q_m_access, 0);
      nxt(); mid();
      chk("first_grant", q_m_access, 1);
      chk("first_owner", q_m_owner, 0);
      chk("first_addr", q_m_addr, 19'h00001);
      // reset in the middle of a grant, with a slave ack on the same cycle
      nxt(); reset = 1; q_m_ack = 1;
      mid(); chk("midrst_ack", {a_m_ack, b_m_ack}, 0);
      nxt(); reset = 0; q_m_ack = 0;
      mid(); chk("midrst_idle", q_m_access, 0);
      nxt(); mid();
      chk("rewin_access", q_m_access, 1);
      chk("rewin_owner", q_m_owner, 0);
      nxt(); q_m_ack = 1;
      mid(); chk("rewin_ack", a_m_ack, 1);
      nxt(); q_m_ack = 0; a_m_access = 0; b_m_access = 0;
      nxt();

      // single read by A, slave acks on the 4th granted cycle (TIMEOUT boundary)
      na0 = na; nb0 = nb; ne0 = ne;
      a_m_addr = 19'h00010; a_m_wr_en = 0; a_m_access = 1;
      nxt(); nxt(); nxt(); nxt();
      q_m_data_in = 16'hBEEF; q_m_ack = 1;
      mid();
      chk("rd_ack", a_m_ack, 1);
      chk("rd_data", a_m_data_in, 16'hBEEF);
      chk("rd_addr", q_m_addr, 19'h00010);
      chk("bnd_no_err", bus_error, 0);
      nxt(); q_m_ack = 0; a_m_access = 0;
      mid(); chk("rd_ack_off", a_m_ack, 0);
      nxt();
      chk("rd_na", na - na0, 1);
      chk("rd_nb", nb - nb0, 0);
      chk("bnd_ne", ne - ne0, 0);

      // contention fairness after a fresh reset
      reset = 1;
      nxt(); reset = 0;
      a_m_addr = 19'h00100; b_m_addr = 19'h00200; a_m_access = 1; b_m_access = 1;
      na0 = na; nb0 = nb; gc = 0; n = 0; pa = 0; pb = 0;
      for (int c = 0; c < 80 && n < 6; c++) begin
         nxt();
         if (pa) begin a_m_addr = a_m_addr + 19'd1; pa = 0; end
         if (pb) begin b_m_addr = b_m_addr + 19'd1; pb = 0; end
         if (q_m_access) gc++; else gc = 0;
         q_m_ack = (gc == 2);
         mid();
         if (q_m_access && q_m_ack) begin
            order[n] = q_m_owner;
            chk("fair_addr", q_m_addr, q_m_owner ? b_m_addr : a_m_addr);
            if (q_m_owner) pb = 1; else pa = 1;
            n++;
         end
      end
      chk("fair_count", n, 6);
      chk("fair_order", order, 6'b010101);
      nxt(); q_m_ack = 0; a_m_access = 0; b_m_access = 0;
      nxt();
      chk("fair_na", na - na0, 3);
      chk("fair_nb", nb - nb0, 3);

      // B write to the LED register; a stray ack while idle afterwards
      na0 = na; nb0 = nb;
      b_m_addr = 19'h7F000; b_m_data_out = 16'h00A5; b_m_bytesel = 2'b01; b_m_wr_en = 1; b_m_access = 1;
      for (int i = 0; i < 3; i++) begin
         nxt();
         q_m_ack = (i == 2);
         mid();
         chk("wr_access", q_m_access, 1);
         chk("wr_en", q_m_wr_en, 1);
         chk("wr_data", q_m_data_out, 16'h00A5);
         chk("wr_bsel", q_m_bytesel, 2'b01);
      end
      chk("wr_ack", b_m_ack, 1);
      nxt(); b_m_access = 0;
      mid();
      chk("wr_idle", q_m_access, 0);
      chk("wr_no_dup", b_m_ack, 0);
      nxt(); q_m_ack = 0;
      nxt();
      chk("wr_nb", nb - nb0, 1);
      chk("wr_na", na - na0, 0);

      // timeout: slave silent, then a late ack during the abort cycle
      na0 = na; ne0 = ne; acc = 0; errs = 0; a_seen = 0;
      a_m_addr = 19'h00ABC; a_m_wr_en = 0; a_m_access = 1;
      for (int c = 0; c < 12; c++) begin
         nxt();
         if (a_seen) a_m_access = 0;
         q_m_ack = (acc == TO && !q_m_access && errs == 0);
         mid();
         if (q_m_access) acc++;
         if (bus_error) begin
            errs++;
            chk("to_ack", a_m_ack, 1);
            chk("to_data", a_m_data_in, 16'hFFFF);
            chk("to_len", acc, TO);
         end
         if (a_m_ack) a_seen = 1;
      end
      chk("to_access_cycles", acc, TO);
      chk("to_errs", errs, 1);
      chk("to_na", na - na0, 1);
      chk("to_ne", ne - ne0, 1);
      q_m_ack = 0;

      // randomized masters, slave and occasional reset
      a_done = 0; b_done = 0;
      for (int c = 0; c < 3000; c++) begin
         nxt();
         acc_now = q_m_access;
         if (a_done) begin a_m_access = ($urandom_range(0, 2) != 0); if (a_m_access) new_a(); end
         else if (!a_m_access && $urandom_range(0, 3) == 0) begin a_m_access = 1; new_a(); end
         if (b_done) begin b_m_access = ($urandom_range(0, 2) != 0); if (b_m_access) new_b(); end
         else if (!b_m_access && $urandom_range(0, 3) == 0) begin b_m_access = 1; new_b(); end
         reset = ($urandom_range(0, 299) == 0);
         q_m_ack = acc_now ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
         q_m_data_in = 16'($urandom);
         a_done = 0; b_done = 0;
         mid();
         if (a_m_ack) a_done = 1;
         if (b_m_ack) b_done = 1;
      end
      nxt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
